// File: rtl/flash_fetch_pkg.sv
// Shared types for the flash sample fetcher: FSM states, word-half selectors and the audio sample type.
package flash_fetch_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    HOLD
  } state_t;

  // Physical halves of a flash word
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic sample_t pick_half(input logic [WORD_W-1:0] word, input logic sel);
    return (sel == HALF_HI) ? sample_t'(word[31:16]) : sample_t'(word[15:0]);
  endfunction

endpackage

// File: rtl/sample_splitter.sv
// Selects the audio sample for the current playback half of a buffered flash word.
// Optional build macro AUDIO_ATTEN_EN adds an arithmetic-shift attenuator.
module sample_splitter
  import flash_fetch_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_half,
  input  logic              i_dir,
`ifdef AUDIO_ATTEN_EN
  input  logic [2:0]        i_atten,
`endif
  output sample_t           o_sample
);

  logic    w_sel;
  sample_t w_raw;

  // i_half is the playback phase; backward playback reverses which physical half comes first
  assign w_sel = i_half ^ i_dir;
  assign w_raw = pick_half(i_word, w_sel);

`ifdef AUDIO_ATTEN_EN
  assign o_sample = w_raw >>> i_atten;
`else
  assign o_sample = w_raw;
`endif

endmodule

// File: rtl/flash_sample_fetch.sv
// Reads one 32-bit word per address from an Avalon-MM flash and plays it out as two 16-bit samples.
// Optional build macro AUDIO_ATTEN_EN adds the atten[2:0] input.
module flash_sample_fetch
  import flash_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic                  dir,
  input  logic                  enable,
  input  logic                  sample_tick,
`ifdef AUDIO_ATTEN_EN
  input  logic [2:0]            atten,
`endif
  output logic                  flash_read,
  output logic [ADDR_W-1:0]     flash_address,
  input  logic                  flash_waitrequest,
  input  logic [31:0]           flash_readdata,
  input  logic                  flash_readdatavalid,
  output logic [15:0]           sample_out,
  output logic                  sample_valid,
  output logic                  addr_step,
  output logic                  timeout_err,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            r_state;
  logic [WORD_W-1:0] r_buf;
  logic              r_half;
  logic              r_dir;
  logic [TO_W-1:0]   r_to_cnt;
  sample_t           w_sample;
  logic              w_tick;

  assign w_tick = sample_tick & enable;

  // Upper address bits are the controller's concern; only the low ADDR_W bits reach flash
  generate
    if (ADDR_W < 32) begin : g_addr_unused
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^addr[31:ADDR_W];
    end
  endgenerate

  sample_splitter u_split (
    .i_word   (r_buf),
    .i_half   (r_half),
    .i_dir    (r_dir),
`ifdef AUDIO_ATTEN_EN
    .i_atten  (atten),
`endif
    .o_sample (w_sample)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_buf         <= '0;
      r_half        <= 1'b0;
      r_dir         <= 1'b0;
      r_to_cnt      <= '0;
      flash_read    <= 1'b0;
      flash_address <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      addr_step     <= 1'b0;
      timeout_err   <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      sample_valid <= 1'b0;
      addr_step    <= 1'b0;
      timeout_err  <= 1'b0;

      // A tick with nothing buffered, including one coincident with capture, is an underrun
      if (w_tick && (r_state != HOLD) && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            flash_address <= addr[ADDR_W-1:0];
            r_dir         <= dir;
            flash_read    <= 1'b1;
            r_state       <= REQ;
          end
        end
        REQ: begin
          if (!flash_waitrequest) begin
            flash_read <= 1'b0;
            r_to_cnt   <= '0;
            r_state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flash_readdatavalid) begin
            r_buf   <= flash_readdata;
            r_half  <= 1'b0;
            r_state <= HOLD;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        HOLD: begin
          if (w_tick) begin
            sample_out   <= w_sample;
            sample_valid <= 1'b1;
            if (!r_half) begin
              r_half <= 1'b1;
            end else begin
              addr_step <= 1'b1;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
